axis_pkt_arbiter: RTL and testbench
===================================

AXIS_PKT_ARBITER -- requirements
Module: axis_pkt_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning the tdata width in bits.
REQ-002 SHALL have parameter NUM_PORTS, default 4, meaning the number of input streams (legal range 2..16).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port s_axis_tdata, input, NUM_PORTS*DATA_WIDTH, where port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-006 SHALL have ports s_axis_tvalid, s_axis_tlast (input) and s_axis_tready (output), each NUM_PORTS wide, one bit per port.
REQ-007 SHALL have ports m_axis_tdata (output, DATA_WIDTH), m_axis_tvalid (output, 1), m_axis_tready (input, 1) and m_axis_tlast (output, 1), forming the merged stream.
REQ-008 SHALL have port grant, output, NUM_PORTS, a one-hot indication of the port that owns the output; all zero when idle.
REQ-009 SHALL have port pkt_done, output, 1, a one-cycle pulse on the output handshake of a beat with tlast high.

Function
REQ-010 SHALL implement a two-state FSM: IDLE (no owner) and BUSY (one port owns the output).
REQ-011 In IDLE with any s_axis_tvalid high, SHALL select a winner round-robin, starting the search at (last_winner+1) mod NUM_PORTS.
REQ-012 On selection SHALL register grant, move to BUSY, and update last_winner on the next edge; the first beat therefore follows one bubble cycle.
REQ-013 In IDLE SHALL drive all s_axis_tready low and m_axis_tvalid low.
REQ-014 In BUSY SHALL drive m_axis_tdata, m_axis_tvalid and m_axis_tlast combinationally from the granted port.
REQ-015 In BUSY SHALL set s_axis_tready[g] = m_axis_tready for the granted port g only, and hold all other s_axis_tready low.
REQ-016 SHALL keep the grant for the whole packet, so beats from different ports never interleave.
REQ-017 On an output handshake with m_axis_tlast=1, SHALL pulse pkt_done and return to IDLE on the same edge.
REQ-018 A port raising tvalid in the same cycle as that tlast handshake SHALL only be considered in the following IDLE cycle (no back-to-back grant).
REQ-019 SHALL tolerate the granted port deasserting tvalid mid-packet: stay BUSY with m_axis_tvalid low until the packet resumes and reaches tlast.
REQ-020 A single-beat packet (tlast on the first beat) SHALL complete in BUSY for one handshake cycle, then return to IDLE.

Reset
REQ-021 On rst_n low SHALL immediately force state=IDLE, grant=0, last_winner=NUM_PORTS-1 (so port 0 wins first), pkt_done=0, m_axis_tvalid=0 and all s_axis_tready=0.
REQ-022 Reset asserted mid-packet SHALL abandon the packet; after reset release arbitration restarts from port 0 with no residual state.

Configuration
REQ-023 Macro AXIS_ARB_PKT_CNT_EN SHALL control per-port packet counting.
REQ-024 With AXIS_ARB_PKT_CNT_EN defined SHALL add output pkt_cnt (NUM_PORTS*32): a 32-bit counter per port that increments on every pkt_done for that port, wraps from 0xFFFFFFFF to 0 and resets to 0.
REQ-025 Without AXIS_ARB_PKT_CNT_EN, the pkt_cnt port and its counters SHALL not exist; all other behaviour SHALL be unchanged.

Structure
REQ-026 SHALL take the FSM state enum (ARB_IDLE, ARB_BUSY) from the shared package etherparse_axis_pkg, together with constant ARB_CNT_W=32.
REQ-027 SHALL place the round-robin selection in sub-module rr_pick: combinational, with inputs req[NUM_PORTS] and last[$clog2(NUM_PORTS)], and outputs onehot and idx.

Verification
REQ-028 Single port: port 2 sends a 3-beat packet (0xA1, 0xA2, 0xA3 with tlast) while m_axis_tready=1 -> grant=0b0100 one cycle after tvalid, three output beats in order, one pkt_done, return to IDLE.
REQ-029 Contention: ports 0, 1 and 3 all valid with 2-beat packets -> served in order 0, 1, 3 with no interleaving and 3 pkt_done pulses.
REQ-030 Fairness: ports 0 and 1 continuously valid for 6 packets -> grants alternate 0, 1, 0, 1, 0, 1.
REQ-031 Backpressure: m_axis_tready toggles 1, 0, 1 mid-packet -> data held stable while stalled, and only the granted port sees tready.
REQ-032 Reset mid-packet: rst_n low during beat 2 of 4 on port 1 -> outputs zero immediately; after release port 0 is considered first.
REQ-033 With AXIS_ARB_PKT_CNT_EN: 5 packets on port 3 -> pkt_cnt[3]=5 and the other counters 0; a preloaded counter at 0xFFFFFFFF wraps to 0.

Source files
------------

// File: rtl/etherparse_axis_pkg.sv
// Shared AXI-Stream definitions: arbiter FSM states, counter width and the
// round-robin wrap helper.
package etherparse_axis_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam int ARB_CNT_W = 32;

  function automatic int unsigned rr_next(input int unsigned cur, input int unsigned n);
    return (cur + 1 >= n) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/axis_pkt_arbiter_rr_pick.sv
// Combinational round-robin picker: the first requester after 'last',
// wrapping modulo NUM_PORTS.
module rr_pick
  import etherparse_axis_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  localparam int IDX_W = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     last,
  output logic [NUM_PORTS-1:0] onehot,
  output logic [IDX_W-1:0]     idx
);

  int unsigned      cand;
  logic [IDX_W-1:0] cand_idx;
  logic             found;

  always_comb begin
    onehot   = '0;
    idx      = '0;
    found    = 1'b0;
    cand     = int'(last);
    cand_idx = last;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand     = rr_next(cand, NUM_PORTS);
      cand_idx = cand[IDX_W-1:0];
      if (!found && req[cand_idx]) begin
        found            = 1'b1;
        onehot[cand_idx] = 1'b1;
        idx              = cand_idx;
      end
    end
  end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-granular round-robin AXI-Stream arbiter (NUM_PORTS inputs, one output).
// Define AXIS_ARB_PKT_CNT_EN to add per-port 32-bit completed-packet counters.
module axis_pkt_arbiter
  import etherparse_axis_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_PORTS  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]            s_axis_tlast,
  output logic [NUM_PORTS-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic [NUM_PORTS-1:0]            grant,
  output logic                            pkt_done
`ifdef AXIS_ARB_PKT_CNT_EN
  ,
  output logic [NUM_PORTS*ARB_CNT_W-1:0]  pkt_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  arb_state_e           state_q, state_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d, pick_onehot;
  logic [IDX_W-1:0]     gidx_q, gidx_d, last_q, last_d, pick_idx;

  rr_pick #(
    .NUM_PORTS(NUM_PORTS)
  ) u_rr_pick (
    .req   (s_axis_tvalid),
    .last  (last_q),
    .onehot(pick_onehot),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IDX_W'(NUM_PORTS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
    end
  end

  // Grant is held until the tlast handshake; the following cycle is always
  // an arbitration (IDLE) cycle, so a new winner never lands back-to-back.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    gidx_d        = gidx_q;
    last_d        = last_q;
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    pkt_done      = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (|s_axis_tvalid) begin
          state_d = ARB_BUSY;
          grant_d = pick_onehot;
          gidx_d  = pick_idx;
          last_d  = pick_idx;
        end
      end
      ARB_BUSY: begin
        m_axis_tdata  = s_axis_tdata[gidx_q*DATA_WIDTH +: DATA_WIDTH];
        m_axis_tvalid = s_axis_tvalid[gidx_q];
        m_axis_tlast  = s_axis_tlast[gidx_q];
        s_axis_tready = grant_q & {NUM_PORTS{m_axis_tready}};
        if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
          pkt_done = 1'b1;
          state_d  = ARB_IDLE;
          grant_d  = '0;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  assign grant = grant_q;

`ifdef AXIS_ARB_PKT_CNT_EN
  logic [ARB_CNT_W-1:0] cnt_q [NUM_PORTS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PORTS; i++) cnt_q[i] <= '0;
    end else if (pkt_done) begin
      cnt_q[gidx_q] <= cnt_q[gidx_q] + ARB_CNT_W'(1);
    end
  end

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_cnt
    assign pkt_cnt[gi*ARB_CNT_W +: ARB_CNT_W] = cnt_q[gi];
  end
`endif

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Self-checking bench for axis_pkt_arbiter: queued random packets per port,
// service order and beat stream predicted by a round-robin packet model.
module tb_axis_pkt_arbiter;

  localparam int DW = 64;
  localparam int NP = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NP*DW-1:0]  s_axis_tdata;
  logic [NP-1:0]     s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [DW-1:0]     m_axis_tdata;
  logic              m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [NP-1:0]     grant;
  logic              pkt_done;
`ifdef AXIS_ARB_PKT_CNT_EN
  logic [NP*32-1:0]  pkt_cnt;
`endif

  always #5 clk = ~clk;

  axis_pkt_arbiter #(.DATA_WIDTH(DW), .NUM_PORTS(NP)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .grant(grant), .pkt_done(pkt_done)
`ifdef AXIS_ARB_PKT_CNT_EN
    , .pkt_cnt(pkt_cnt)
`endif
  );

  typedef struct packed { logic [DW-1:0] data; logic first; logic last; } beat_t;
  typedef struct packed { logic [3:0] port; logic [DW-1:0] data; logic last; } obs_t;

  beat_t src_q [NP][$];
  beat_t mdl_q [NP][$];
  int    grant_log[$];
  obs_t  beat_log[$];
  int    exp_grant[$];
  obs_t  exp_beat[$];
  int    done_cnt, viol_cnt, mdl_last;
  bit    gaps_en, rdy_rand;
  int    n_tests, n_fail;

  // Source side: present the head beat of each port queue; first beats are
  // always valid, later beats may gap when gaps_en is set.
  initial begin : driver
    logic [NP-1:0] hs;
    s_axis_tvalid = '0; s_axis_tlast = '0; s_axis_tdata = '0; m_axis_tready = 1'b1;
    forever begin
      @(negedge clk);
      hs = s_axis_tvalid & s_axis_tready;
      @(posedge clk); #1;
      for (int i = 0; i < NP; i++) begin
        if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() == 0) begin
          s_axis_tvalid[i] = 1'b0;
          s_axis_tlast[i]  = 1'b0;
          s_axis_tdata[i*DW +: DW] = '0;
        end else begin
          s_axis_tvalid[i] = src_q[i][0].first || !gaps_en || ($urandom_range(3) != 0);
          s_axis_tlast[i]  = src_q[i][0].last;
          s_axis_tdata[i*DW +: DW] = src_q[i][0].data;
        end
      end
      m_axis_tready = rdy_rand ? ($urandom_range(2) != 0) : 1'b1;
    end
  end

  // Observer: logs grants, output beats and pkt_done; counts rule breaches.
  initial begin : monitor
    logic [NP-1:0] prev_grant;
    logic          prev_stall, prev_done;
    logic [DW-1:0] prev_data;
    int            gi;
    prev_grant = '0; prev_stall = 1'b0; prev_done = 1'b0; prev_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_grant = '0; prev_stall = 1'b0; prev_done = 1'b0;
      end else begin
        gi = 0;
        for (int i = 0; i < NP; i++) if (grant[i]) gi = i;
        if (grant != '0 && prev_grant == '0) grant_log.push_back(gi);
        if ($countones(grant) > 1) viol_cnt++;
        if (prev_done && grant != '0) viol_cnt++;
        if (grant == '0) begin
          if (m_axis_tvalid || s_axis_tready != '0) viol_cnt++;
        end else begin
          if (s_axis_tready !== (grant & {NP{m_axis_tready}})) viol_cnt++;
          if (m_axis_tvalid !== s_axis_tvalid[gi]) viol_cnt++;
          if (m_axis_tvalid && m_axis_tdata !== s_axis_tdata[gi*DW +: DW]) viol_cnt++;
        end
        if (prev_stall && m_axis_tvalid && m_axis_tdata !== prev_data) viol_cnt++;
        if (pkt_done !== (m_axis_tvalid & m_axis_tready & m_axis_tlast)) viol_cnt++;
        if (m_axis_tvalid && m_axis_tready) begin
          obs_t o;
          o.port = 4'(gi); o.data = m_axis_tdata; o.last = m_axis_tlast;
          beat_log.push_back(o);
        end
        if (pkt_done) done_cnt++;
        prev_grant = grant;
        prev_stall = m_axis_tvalid & ~m_axis_tready;
        prev_data  = m_axis_tdata;
        prev_done  = pkt_done;
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_beat(input int p, input logic [DW-1:0] d, input bit f, input bit l);
    beat_t b;
    b.data = d; b.first = f; b.last = l;
    src_q[p].push_back(b);
    mdl_q[p].push_back(b);
  endtask

  task automatic load_pkt(input int p, input int len);
    for (int k = 0; k < len; k++)
      push_beat(p, {$urandom, $urandom}, k == 0, k == len - 1);
  endtask

  task automatic clear_logs();
    grant_log.delete(); beat_log.delete(); done_cnt = 0; viol_cnt = 0;
  endtask

  // Packets are served whole; each new owner is the first port after the
  // previous owner that still has a packet waiting.
  task automatic model_run();
    int p; bit any; beat_t b; obs_t o;
    exp_grant.delete(); exp_beat.delete();
    while (1) begin
      any = 0;
      for (int i = 0; i < NP; i++) if (mdl_q[i].size() > 0) any = 1;
      if (!any) break;
      p = mdl_last;
      do p = (p + 1) % NP; while (mdl_q[p].size() == 0);
      exp_grant.push_back(p);
      do begin
        b = mdl_q[p].pop_front();
        o.port = 4'(p); o.data = b.data; o.last = b.last;
        exp_beat.push_back(o);
      end while (!b.last);
      mdl_last = p;
    end
  endtask

  task automatic wait_idle(input int max_cyc, output bit to);
    bit empty;
    to = 1'b1;
    for (int n = 0; n < max_cyc; n++) begin
      @(negedge clk);
      empty = 1'b1;
      for (int i = 0; i < NP; i++) if (src_q[i].size() != 0) empty = 1'b0;
      if (empty && grant == '0) begin to = 1'b0; break; end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    mdl_last = NP - 1;
  endtask

  task automatic test_reset();
    bit to;
    rst_n = 1'b0; mdl_last = NP - 1;
    clear_logs();
    load_pkt(0, 2);
    model_run();
    repeat (3) @(negedge clk);
    n_tests++; if (grant !== '0) begin n_fail++; $display("FAIL reset grant: got %b want 0", grant); end
    n_tests++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset m_tvalid: got %b want 0", m_axis_tvalid); end
    n_tests++; if (s_axis_tready !== '0) begin n_fail++; $display("FAIL reset s_tready: got %b want 0", s_axis_tready); end
    n_tests++; if (pkt_done !== 1'b0) begin n_fail++; $display("FAIL reset pkt_done: got %b want 0", pkt_done); end
    @(posedge clk); #1 rst_n = 1'b1;
    wait_idle(200, to);
    n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL reset timeout: got %0b want 0", to); end
    n_tests++; if (grant_log.size() !== 1 || grant_log[0] !== 0) begin n_fail++; $display("FAIL reset first_grant: got %p want 0", grant_log); end
    n_tests++; if (beat_log.size() !== exp_beat.size() || beat_log[1] !== exp_beat[1]) begin n_fail++; $display("FAIL reset beats: got %0d beats want %0d", beat_log.size(), exp_beat.size()); end
  endtask

  task automatic test_single_port();
    bit to; int n;
    clear_logs();
    push_beat(2, 64'hA1, 1, 0); push_beat(2, 64'hA2, 0, 0); push_beat(2, 64'hA3, 0, 1);
    model_run();
    for (n = 0; n < 5; n++) begin @(negedge clk); if (s_axis_tvalid[2]) break; end
    n_tests++; if (grant !== '0) begin n_fail++; $display("FAIL single bubble_grant: got %b want 0000", grant); end
    @(negedge clk);
    n_tests++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL single grant: got %b want 0100", grant); end
    n_tests++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 64'hA1) begin n_fail++; $display("FAIL single first_beat: got v=%b d=%h want v=1 d=a1", m_axis_tvalid, m_axis_tdata); end
    wait_idle(200, to);
    n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL single timeout: got %0b want 0", to); end
    n_tests++; if (beat_log.size() !== 3) begin n_fail++; $display("FAIL single beat_count: got %0d want 3", beat_log.size()); end
    for (int i = 0; i < 3 && i < beat_log.size(); i++) begin
      n_tests++; if (beat_log[i] !== exp_beat[i]) begin n_fail++; $display("FAIL single beat[%0d]: got %h want %h", i, beat_log[i], exp_beat[i]); end
    end
    n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL single pkt_done: got %0d want 1", done_cnt); end
    n_tests++; if (viol_cnt !== 0) begin n_fail++; $display("FAIL single rules: got %0d breaches want 0", viol_cnt); end
  endtask

  // Shared shape for the traffic scenarios: load, run the model, wait, compare.
  task automatic test_traffic(input string nm, input int kind);
    bit to;
    clear_logs();
    case (kind)
      0: begin pulse_reset(); clear_logs(); load_pkt(0, 2); load_pkt(1, 2); load_pkt(3, 2); end
      1: for (int k = 0; k < 3; k++) begin load_pkt(0, $urandom_range(1, 3)); load_pkt(1, $urandom_range(1, 3)); end
      2: for (int k = 0; k < 2; k++) for (int p = 0; p < NP; p++) load_pkt(p, 1);
      default: for (int k = 0; k < 3; k++) for (int p = 0; p < NP; p++) load_pkt(p, $urandom_range(1, 5));
    endcase
    model_run();
    wait_idle(3000, to);
    n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL %s timeout: got %0b want 0", nm, to); end
    n_tests++; if (grant_log.size() !== exp_grant.size()) begin n_fail++; $display("FAIL %s grant_count: got %0d want %0d", nm, grant_log.size(), exp_grant.size()); end
    for (int i = 0; i < exp_grant.size() && i < grant_log.size(); i++) begin
      n_tests++; if (grant_log[i] !== exp_grant[i]) begin n_fail++; $display("FAIL %s grant[%0d]: got %0d want %0d", nm, i, grant_log[i], exp_grant[i]); end
    end
    n_tests++; if (beat_log.size() !== exp_beat.size()) begin n_fail++; $display("FAIL %s beat_count: got %0d want %0d", nm, beat_log.size(), exp_beat.size()); end
    for (int i = 0; i < exp_beat.size() && i < beat_log.size(); i++) begin
      n_tests++; if (beat_log[i] !== exp_beat[i]) begin n_fail++; $display("FAIL %s beat[%0d]: got %h want %h", nm, i, beat_log[i], exp_beat[i]); end
    end
    n_tests++; if (done_cnt !== exp_grant.size()) begin n_fail++; $display("FAIL %s pkt_done: got %0d want %0d", nm, done_cnt, exp_grant.size()); end
    n_tests++; if (viol_cnt !== 0) begin n_fail++; $display("FAIL %s rules: got %0d breaches want 0", nm, viol_cnt); end
  endtask

  task automatic test_reset_mid_packet();
    bit to;
    gaps_en = 0; rdy_rand = 0;
    clear_logs();
    load_pkt(1, 4);
    model_run();
    for (int n = 0; n < 20; n++) begin @(negedge clk); #1; if (beat_log.size() >= 1) break; end
    @(negedge clk); #2;
    n_tests++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_beat[1].data) begin n_fail++; $display("FAIL midrst beat2: got v=%b d=%h want v=1 d=%h", m_axis_tvalid, m_axis_tdata, exp_beat[1].data); end
    rst_n = 1'b0; #1;
    n_tests++; if (grant !== '0 || m_axis_tvalid !== 1'b0 || s_axis_tready !== '0 || pkt_done !== 1'b0)
      begin n_fail++; $display("FAIL midrst outputs: got g=%b v=%b r=%b d=%b want all 0", grant, m_axis_tvalid, s_axis_tready, pkt_done); end
    for (int i = 0; i < NP; i++) begin src_q[i].delete(); mdl_q[i].delete(); end
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    mdl_last = NP - 1;
    clear_logs();
    load_pkt(1, 2); load_pkt(0, 2);
    model_run();
    wait_idle(300, to);
    n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL midrst timeout: got %0b want 0", to); end
    n_tests++; if (grant_log.size() !== 2 || grant_log[0] !== 0 || grant_log[1] !== 1) begin n_fail++; $display("FAIL midrst order: got %p want 0 1", grant_log); end
    n_tests++; if (beat_log.size() !== exp_beat.size() || beat_log[0] !== exp_beat[0]) begin n_fail++; $display("FAIL midrst beats: got %0d want %0d", beat_log.size(), exp_beat.size()); end
  endtask

`ifdef AXIS_ARB_PKT_CNT_EN
  task automatic test_pkt_cnt();
    bit to;
    pulse_reset();
    clear_logs();
    for (int k = 0; k < 5; k++) load_pkt(3, $urandom_range(1, 3));
    model_run();
    wait_idle(500, to);
    for (int p = 0; p < NP; p++) begin
      n_tests++; if (pkt_cnt[p*32 +: 32] !== ((p == 3) ? 32'd5 : 32'd0)) begin n_fail++; $display("FAIL pkt_cnt[%0d]: got %0d want %0d", p, pkt_cnt[p*32 +: 32], (p == 3) ? 5 : 0); end
    end
    @(negedge clk); dut.cnt_q[3] = 32'hFFFF_FFFF;
    load_pkt(3, 1);
    model_run();
    wait_idle(200, to);
    n_tests++; if (pkt_cnt[3*32 +: 32] !== 32'd0) begin n_fail++; $display("FAIL pkt_cnt wrap: got %h want 0", pkt_cnt[3*32 +: 32]); end
  endtask
`endif

  initial begin
    n_tests = 0; n_fail = 0; gaps_en = 0; rdy_rand = 0;
    done_cnt = 0; viol_cnt = 0; mdl_last = NP - 1;
    test_reset();
    test_single_port();
    test_traffic("contention", 0);
    test_traffic("fairness", 1);
    test_traffic("single_beat", 2);
    gaps_en = 1; rdy_rand = 1;
    test_traffic("backpressure", 3);
    test_reset_mid_packet();
`ifdef AXIS_ARB_PKT_CNT_EN
    test_pkt_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
